// File: rtl/pipe_ctrl_hazard.sv
// pipe_ctrl_hazard: EX/MEM/WB control pipeline with load-use bubbles, branch/jump flush and EX forwarding.
// Define PIPE_STATS_EN to add saturating stall/flush/memwait counters.
module pipe_ctrl_hazard #(
    parameter int REG_W   = 5,
    parameter int ALUOP_W = 6
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               id_valid,
    input  logic               id_jump,
    input  logic               id_branch,
    input  logic               id_memread,
    input  logic               id_memwrite,
    input  logic               id_memtoreg,
    input  logic               id_regdst,
    input  logic               id_regwrite,
    input  logic               id_alusrc,
    input  logic [ALUOP_W-1:0] id_aluop,
    input  logic [REG_W-1:0]   id_rs,
    input  logic [REG_W-1:0]   id_rt,
    input  logic [REG_W-1:0]   id_rd,
    input  logic               ex_branch_taken,
    input  logic               mem_stall,
    output logic               ex_valid,
    output logic               mem_valid,
    output logic               wb_valid,
    output logic               ex_alusrc,
    output logic               ex_branch,
    output logic [ALUOP_W-1:0] ex_aluop,
    output logic [REG_W-1:0]   ex_rs,
    output logic [REG_W-1:0]   ex_rt,
    output logic [REG_W-1:0]   ex_wreg,
    output logic               mem_memread,
    output logic               mem_memwrite,
    output logic [REG_W-1:0]   mem_wreg,
    output logic               wb_regwrite,
    output logic               wb_memtoreg,
    output logic [REG_W-1:0]   wb_wreg,
    output logic [1:0]         fwd_a,
    output logic [1:0]         fwd_b,
    output logic               pc_write,
    output logic               ifid_write,
    output logic               ifid_flush
`ifdef PIPE_STATS_EN
    ,
    output logic [15:0]        stat_stall,
    output logic [15:0]        stat_flush,
    output logic [15:0]        stat_memwait
`endif
);

    typedef struct packed {
        logic               valid;
        logic               alusrc;
        logic               branch;
        logic               memread;
        logic               memwrite;
        logic               regwrite;
        logic               memtoreg;
        logic [ALUOP_W-1:0] aluop;
        logic [REG_W-1:0]   rs;
        logic [REG_W-1:0]   rt;
        logic [REG_W-1:0]   wreg;
    } exStage_t;

    typedef struct packed {
        logic             valid;
        logic             memread;
        logic             memwrite;
        logic             regwrite;
        logic             memtoreg;
        logic [REG_W-1:0] wreg;
    } memStage_t;

    typedef struct packed {
        logic             valid;
        logic             regwrite;
        logic             memtoreg;
        logic [REG_W-1:0] wreg;
    } wbStage_t;

    exStage_t   exQ, idCap;
    memStage_t  memQ;
    wbStage_t   wbQ;
    logic [REG_W-1:0] idWreg;
    logic rtUsed, loadUse, taken, idJump;

    assign idWreg = id_regdst ? id_rd : id_rt;
    // writes to $0 are dropped here so forwarding never sees them
    assign idCap  = id_valid ? exStage_t'{1'b1, id_alusrc, id_branch, id_memread, id_memwrite,
                                          id_regwrite && idWreg != '0, id_memtoreg, id_aluop,
                                          id_rs, id_rt, idWreg} : '0;
    assign rtUsed  = !id_alusrc || id_memwrite;
    assign loadUse = id_valid && exQ.valid && exQ.memread && exQ.wreg != '0 &&
                     (exQ.wreg == id_rs || (rtUsed && exQ.wreg == id_rt));
    assign taken   = exQ.valid && exQ.branch && ex_branch_taken;
    assign idJump  = id_valid && id_jump;

    always_ff @(posedge clk) begin
        if (reset) begin
            exQ  <= '0;
            memQ <= '0;
            wbQ  <= '0;
        end else if (!mem_stall) begin
            exQ  <= (taken || loadUse) ? '0 : idCap;
            memQ <= '{exQ.valid, exQ.memread, exQ.memwrite, exQ.regwrite, exQ.memtoreg, exQ.wreg};
            wbQ  <= '{memQ.valid, memQ.regwrite, memQ.memtoreg, memQ.wreg};
        end
    end

    function automatic logic [1:0] fwdSel(input logic [REG_W-1:0] r, input memStage_t m, input wbStage_t w);
        return (m.valid && m.regwrite && m.wreg != '0 && m.wreg == r) ? 2'b10 :
               (w.valid && w.regwrite && w.wreg != '0 && w.wreg == r) ? 2'b01 : 2'b00;
    endfunction

    assign fwd_a = fwdSel(exQ.rs, memQ, wbQ);
    assign fwd_b = fwdSel(exQ.rt, memQ, wbQ);

    assign pc_write   = !reset && !mem_stall && (taken || !loadUse);
    assign ifid_write = pc_write;
    assign ifid_flush = reset || (!mem_stall && (taken || (!loadUse && idJump)));

    assign ex_valid     = exQ.valid;
    assign ex_alusrc    = exQ.alusrc;
    assign ex_branch    = exQ.branch;
    assign ex_aluop     = exQ.aluop;
    assign ex_rs        = exQ.rs;
    assign ex_rt        = exQ.rt;
    assign ex_wreg      = exQ.wreg;
    assign mem_valid    = memQ.valid;
    assign mem_memread  = memQ.memread;
    assign mem_memwrite = memQ.memwrite;
    assign mem_wreg     = memQ.wreg;
    assign wb_valid     = wbQ.valid;
    assign wb_regwrite  = wbQ.regwrite;
    assign wb_memtoreg  = wbQ.memtoreg;
    assign wb_wreg      = wbQ.wreg;

`ifdef PIPE_STATS_EN
    logic stallCyc, flushCyc;

    assign stallCyc = !mem_stall && !taken && loadUse;
    assign flushCyc = !mem_stall && (taken || (!loadUse && idJump));

    always_ff @(posedge clk) begin
        if (reset) begin
            stat_stall   <= '0;
            stat_flush   <= '0;
            stat_memwait <= '0;
        end else begin
            if (stallCyc && stat_stall != 16'hFFFF) stat_stall <= stat_stall + 16'd1;
            if (flushCyc && stat_flush != 16'hFFFF) stat_flush <= stat_flush + 16'd1;
            if (mem_stall && stat_memwait != 16'hFFFF) stat_memwait <= stat_memwait + 16'd1;
        end
    end
`endif

endmodule

// File: doc/pipe_ctrl_hazard.md
Name: pipe_ctrl_hazard

Overview:
- Consumes the decoded control bundle from the ID-stage control decoder.
- Carries that bundle through the EX, MEM and WB pipeline control registers.
- Detects load-use hazards and inserts bubbles, squashes wrong-path instructions on taken branches and jumps, and generates EX-stage forwarding selects.
- Sits between the decoder and the datapath pipeline registers; it is the sole owner of PC and IF/ID write enables.

Parameters:
- REG_W, 5, register address width.
- ALUOP_W, 6, width of the AluOp field.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- id_valid  in  1  ID slot holds a real instruction
- id_jump, id_branch, id_memread, id_memwrite, id_memtoreg, id_regdst, id_regwrite, id_alusrc  in  1 each  decoded controls
- id_aluop  in  ALUOP_W  decoded ALU op
- id_rs, id_rt, id_rd  in  REG_W  instruction register fields
- ex_branch_taken  in  1  branch comparison result from EX
- mem_stall  in  1  data memory not ready
- ex_valid, mem_valid, wb_valid  out  1  stage occupancy
- ex_alusrc, ex_branch  out  1  EX controls
- ex_aluop  out  ALUOP_W  EX ALU op
- ex_rs, ex_rt, ex_wreg  out  REG_W  EX register numbers
- mem_memread, mem_memwrite  out  1  MEM controls
- mem_wreg  out  REG_W  MEM destination register
- wb_regwrite, wb_memtoreg  out  1  WB controls
- wb_wreg  out  REG_W  WB destination register
- fwd_a, fwd_b  out  2  forwarding selects: 00 regfile, 10 from MEM, 01 from WB
- pc_write, ifid_write, ifid_flush  out  1  front-end control

Behaviour:
- Three stage registers: EX, MEM, WB. Each holds valid, its controls, and wreg. MEM and WB also carry regwrite and memtoreg.
- A bubble is valid=0 with every control 0.
- Capture on ID->EX:
  - wreg = id_regdst ? id_rd : id_rt.
  - regwrite is forced to 0 when wreg==0.
  - id_valid=0 captures a bubble.
- rt is "used" by the ID instruction when (!id_alusrc || id_memwrite).
- Load-use hazard (combinational) = id_valid & ex_valid & ex_memread & ex_wreg!=0 & (ex_wreg==id_rs | (rt used & ex_wreg==id_rt)).
- Taken branch (combinational) = ex_valid & ex_branch & ex_branch_taken.
- Per-cycle priority:
  1. reset: state cleared to bubbles; outputs pc_write=0, ifid_write=0, ifid_flush=1.
  2. mem_stall: all stage registers hold; pc_write=0, ifid_write=0, ifid_flush=0. This includes a pending taken branch, which resolves when the stall drops.
  3. taken branch: EX<=bubble (squash ID), MEM<=EX, WB<=MEM, ifid_flush=1, pc_write=1, ifid_write=1. Overrides load-use and any jump in ID.
  4. load-use: EX<=bubble, MEM<=EX, WB<=MEM, pc_write=0, ifid_write=0, ifid_flush=0.
  5. jump in ID (id_valid & id_jump): jump advances into EX normally, ifid_flush=1, pc_write=1.
  6. normal: all stages advance, pc_write=1, ifid_write=1, ifid_flush=0.
- Forwarding (combinational from stage registers):
  - fwd_a=10 if mem_valid & mem_regwrite & mem_wreg!=0 & mem_wreg==ex_rs.
  - Else fwd_a=01 if the same condition holds on the WB stage.
  - Else fwd_a=00.
  - fwd_b is identical using ex_rt.
  - MEM has priority over WB.
- A MEM-stage load never forwards to EX, because load-use insertion guarantees distance >= 2.
- Reset mid-operation discards all in-flight stages on that edge; the first post-reset cycle shows all valid=0 and fwd=00.
- Stage latency: one cycle per stage; no combinational path from id_* to stage outputs except through hazard logic.

Optional Feature:
PIPE_STATS_EN
- Defined: adds outputs stat_stall, stat_flush, stat_memwait, each 16 bits. These are saturating counters (hold at 16'hFFFF) of load-use bubble cycles, taken-branch or jump flush cycles, and mem_stall cycles. All cleared by reset.
- Undefined: the ports and logic are absent; all other behaviour is identical.

Test Plan:
- lw $1 ($1 in wreg) then add $3,$1,$2: exactly 1 bubble, pc_write=0 for 1 cycle, then fwd_a=01 when the add is in EX.
- add $1,.. then sub $4,$1,$1 back-to-back: no stall; fwd_a=fwd_b=10 in the sub's EX cycle.
- beq in EX with ex_branch_taken=1 while lw-use is pending in ID: ifid_flush=1, pc_write=1, no bubble count, squashed instruction never reaches MEM.
- j in ID: ifid_flush=1 for one cycle; the jump reaches WB with valid=1, regwrite=0.
- mem_stall=1 for 3 cycles with an add in MEM: all stage outputs and fwd selects are constant, pc_write=0; the pipeline resumes exactly where it was.
- Write to $0 (add $0,$1,$2) followed by a reader of $0: no forwarding (fwd=00), wb_regwrite=0. Assert reset mid-stream: the next cycle has all valid=0.
